spi_bridge: RTL and testbench



---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_bridge_if.sv | 33 +++
 rtl/bit_sync.sv | 24 ++
 rtl/spi_bridge.sv | 129 ++++++++++++
 tb/tb_spi_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI target front-end.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W    = 8;
  localparam int unsigned SPI_BIT_CNT_W = 3;
  localparam logic [SPI_BYTE_W-1:0] SPI_TX_IDLE = 8'h00;

  typedef enum logic {
    StIdle,
    StActive
  } spi_state_e;

endpackage

// File: rtl/spi_bridge_if.sv
// SPI pins plus the byte-level decoder handshake of spi_bridge.
interface spi_bridge_if;
  import spi_pkg::*;

  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  byte_sync;
  logic [SPI_BYTE_W-1:0] data_rx;
  logic [SPI_BYTE_W-1:0] data_tx;

  modport slave (
    input  sclk,
    input  cs_n,
    input  mosi,
    input  data_tx,
    output miso,
    output byte_sync,
    output data_rx
  );

  modport master (
    output sclk,
    output cs_n,
    output mosi,
    output data_tx,
    input  miso,
    input  byte_sync,
    input  data_rx
  );

endinterface

// File: rtl/bit_sync.sv
// Single-bit synchroniser chain with a configurable reset level.
module bit_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_bridge.sv
// SPI mode-0 target: oversamples the pins in the clk domain, deserialises MOSI into bytes
// and serialises the decoder's return byte onto MISO.
module spi_bridge import spi_pkg::*; #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_bridge_if.slave  bus
);

  logic sclk_s, cs_n_s, mosi_s;

  bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.sclk),
    .q     (sclk_s)
  );

  bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.cs_n),
    .q     (cs_n_s)
  );

  bit_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.mosi),
    .q     (mosi_s)
  );

  logic sclk_q, cs_n_q;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      cs_n_q <= cs_n_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = ~cs_n_s & cs_n_q;
  assign cs_rise   = cs_n_s & ~cs_n_q;

  spi_state_e                 state_q, state_d;
  logic [SPI_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0]      rx_shift_q, rx_shift_d;
  logic [SPI_BYTE_W-1:0]      tx_shift_q, tx_shift_d;
  logic [SPI_BYTE_W-1:0]      data_rx_q;
  logic                       done_q, done_d;
  logic                       byte_sync_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d    = StActive;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = SPI_TX_IDLE;
        end
      end
      StActive: begin
        // cs_n rise takes priority so a racing 8th rise never completes a byte
        if (cs_rise) begin
          state_d   = StIdle;
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + SPI_BIT_CNT_W'(1);
          done_d     = (bit_cnt_q == '1);
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0) begin
            tx_shift_d = bus.data_tx;
          end else begin
            tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      done_q     <= done_d;
    end
  end

  // Completed byte is published one cycle after capture, together with its strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_rx_q   <= '0;
      byte_sync_q <= 1'b0;
    end else begin
      byte_sync_q <= done_q;
      if (done_q) begin
        data_rx_q <= rx_shift_q;
      end
    end
  end

  assign bus.miso      = (state_q == StActive) ? tx_shift_q[SPI_BYTE_W-1] : 1'b0;
  assign bus.byte_sync = byte_sync_q;
  assign bus.data_rx   = data_rx_q;

endmodule

// File: tb/tb_spi_bridge.sv
// Self-checking bench for spi_bridge: directed scenarios plus randomized frames checked
// against a byte-level model of what the host should see.
module tb_spi_bridge;
  import spi_pkg::*;

  localparam int unsigned SYNC = 2;
  localparam int          HALF = 4;  // sclk half period in clk cycles (f_clk = 8 x f_sclk)

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_bridge_if bus();

  spi_bridge #(.SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int sync_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] tx_plan[$];
  logic [7:0] tx_log[$];
  logic [7:0] send_q[$];
  logic [7:0] miso_seen[$];

  // Collects every strobe and checks it is exactly one cycle wide
  initial begin
    logic prev_sync;
    prev_sync = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.byte_sync === 1'b1) begin
        got_q.push_back(bus.data_rx);
        sync_cnt++;
        n_cmp++;
        if (prev_sync !== 1'b0) begin
          n_fail++;
          $display("FAIL sync_width: byte_sync high for a second cycle, prev=%b required 0",
                   prev_sync);
        end
      end
      prev_sync = bus.byte_sync;
    end
  end

  // Decoder stand-in: answers each byte two cycles after its strobe
  initial begin
    logic [7:0] v;
    bus.data_tx = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && bus.byte_sync === 1'b1) begin
        @(posedge clk);
        @(posedge clk);
        #1;
        if (tx_plan.size() > 0) v = tx_plan.pop_front();
        else v = 8'($urandom);
        bus.data_tx = v;
        tx_log.push_back(v);
      end
    end
  end

  task automatic shift_bits(input logic [7:0] b, input int nbits, output logic [7:0] m);
    m = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      m[7-i] = bus.miso;
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int tail_bits);
    logic [7:0] m;
    logic [7:0] r;
    miso_seen.delete();
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    foreach (send_q[i]) begin
      shift_bits(send_q[i], 8, m);
      miso_seen.push_back(m);
    end
    if (tail_bits > 0) begin
      r = 8'($urandom);
      shift_bits(r, tail_bits, m);
    end
    repeat (HALF) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (SYNC + 6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.sclk = 1'($urandom);
      bus.mosi = 1'($urandom);
      bus.cs_n = 1'($urandom);
      #1;
      n_cmp++;
      if (bus.miso !== 1'b0 || bus.byte_sync !== 1'b0 || bus.data_rx !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold: miso=%b byte_sync=%b data_rx=%h required 0/0/00",
                 bus.miso, bus.byte_sync, bus.data_rx);
      end
    end
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    n_cmp++;
    if (bus.miso !== 1'b0 || bus.byte_sync !== 1'b0 || bus.data_rx !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: miso=%b byte_sync=%b data_rx=%h required 0/0/00",
               bus.miso, bus.byte_sync, bus.data_rx);
    end
  endtask

  task automatic test_write();
    int base;
    logic [7:0] exp_b[2];
    logic [7:0] act;
    exp_b[0] = 8'h85;
    exp_b[1] = 8'hA5;
    got_q.delete();
    base = sync_cnt;
    send_q = '{8'h85, 8'hA5};
    run_frame(0);
    n_cmp++;
    if (sync_cnt - base !== 2) begin
      n_fail++;
      $display("FAIL write_pulses: got %0d strobes, required 2", sync_cnt - base);
    end
    for (int i = 0; i < 2; i++) begin
      act = (i < got_q.size()) ? got_q[i] : 8'hxx;
      n_cmp++;
      if (act !== exp_b[i]) begin
        n_fail++;
        $display("FAIL write_byte%0d: data_rx=%h required %h", i, act, exp_b[i]);
      end
    end
    n_cmp++;
    if (miso_seen[0] !== SPI_TX_IDLE) begin
      n_fail++;
      $display("FAIL write_miso0: host saw %h, required %h", miso_seen[0], SPI_TX_IDLE);
    end
    n_cmp++;
    if (bus.data_rx !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_hold: data_rx=%h required a5", bus.data_rx);
    end
  endtask

  task automatic test_read();
    logic [7:0] act;
    got_q.delete();
    tx_plan.delete();
    tx_plan.push_back(8'h3C);
    send_q = '{8'h03, 8'h00};
    run_frame(0);
    act = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_cmp++;
    if (act !== 8'h03) begin
      n_fail++;
      $display("FAIL read_cmd: data_rx=%h required 03", act);
    end
    n_cmp++;
    if (miso_seen[1] !== 8'h3C) begin
      n_fail++;
      $display("FAIL read_miso: host saw %h, required 3c", miso_seen[1]);
    end
  endtask

  task automatic test_abort();
    int base;
    logic [7:0] act;
    got_q.delete();
    base = sync_cnt;
    send_q.delete();
    run_frame(5);
    n_cmp++;
    if (sync_cnt - base !== 0) begin
      n_fail++;
      $display("FAIL abort_partial: got %0d strobes, required 0", sync_cnt - base);
    end
    send_q = '{8'h5A};
    run_frame(0);
    act = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_cmp++;
    if (sync_cnt - base !== 1 || act !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_next: strobes=%0d data_rx=%h required 1 strobe with 5a",
               sync_cnt - base, act);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [7:0] m;
    logic [7:0] act;
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(8'hFF, 3, m);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.miso !== 1'b0 || bus.byte_sync !== 1'b0 || bus.data_rx !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid: miso=%b byte_sync=%b data_rx=%h required 0/0/00",
               bus.miso, bus.byte_sync, bus.data_rx);
    end
    bus.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
    got_q.delete();
    base = sync_cnt;
    send_q = '{8'hC3};
    run_frame(0);
    act = (got_q.size() > 0) ? got_q[0] : 8'hxx;
    n_cmp++;
    if (sync_cnt - base !== 1 || act !== 8'hC3) begin
      n_fail++;
      $display("FAIL reset_mid_next: strobes=%0d data_rx=%h required 1 strobe with c3",
               sync_cnt - base, act);
    end
  endtask

  task automatic test_race();
    int base;
    logic [7:0] m;
    logic [7:0] b;
    b = 8'($urandom);
    base = sync_cnt;
    bus.cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    shift_bits(b, 7, m);
    bus.mosi = b[0];
    repeat (HALF) @(negedge clk);
    bus.sclk = 1'b1;
    bus.cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    bus.sclk = 1'b0;
    repeat (SYNC + 6) @(negedge clk);
    n_cmp++;
    if (sync_cnt - base !== 0) begin
      n_fail++;
      $display("FAIL race_pulse: got %0d strobes, required 0", sync_cnt - base);
    end
    n_cmp++;
    if (bus.data_rx !== 8'hC3) begin
      n_fail++;
      $display("FAIL race_hold: data_rx=%h required c3", bus.data_rx);
    end
  endtask

  task automatic test_random();
    int nb, tail, base, log_base;
    logic [7:0] act, exp_m;
    for (int f = 0; f < 30; f++) begin
      nb = int'($urandom_range(1, 4));
      tail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      send_q.delete();
      for (int i = 0; i < nb; i++) send_q.push_back(8'($urandom));
      got_q.delete();
      tx_plan.delete();
      base = sync_cnt;
      log_base = tx_log.size();
      run_frame(tail);
      n_cmp++;
      if (sync_cnt - base !== nb) begin
        n_fail++;
        $display("FAIL rand%0d_pulses: got %0d strobes, required %0d", f, sync_cnt - base, nb);
      end
      for (int i = 0; i < nb; i++) begin
        act = (i < got_q.size()) ? got_q[i] : 8'hxx;
        n_cmp++;
        if (act !== send_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_rx%0d: data_rx=%h required %h", f, i, act, send_q[i]);
        end
        // Host sees 0x00 first, then whatever the decoder answered to the previous byte
        exp_m = (i == 0) ? SPI_TX_IDLE
              : ((log_base + i - 1 < tx_log.size()) ? tx_log[log_base + i - 1] : 8'hxx);
        n_cmp++;
        if (miso_seen[i] !== exp_m) begin
          n_fail++;
          $display("FAIL rand%0d_miso%0d: host saw %h, required %h", f, i, miso_seen[i], exp_m);
        end
      end
      n_cmp++;
      if (bus.data_rx !== send_q[nb-1]) begin
        n_fail++;
        $display("FAIL rand%0d_hold: data_rx=%h required %h", f, bus.data_rx, send_q[nb-1]);
      end
    end
  endtask

  initial begin
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_reset_mid();
    test_race();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
